ttl_reduce_gate_seq: RTL and testbench
======================================

# ttl_reduce_gate_seq

Parametrised sequential wide-input gate: generalises the fixed 8-input NAND into a configurable AND/OR/XOR reduction, with optional inversion, over a `WIDTH_IN`-bit operand. The operand is presented as `CHUNK`-bit slices over successive clock cycles under a valid/ready handshake. It sits alongside the combinational gate models wherever a wide gate must be fed from a narrow bus. The result is registered and qualified by a one-cycle valid pulse.

## Interface
- `WIDTH_IN`, 32: total gate inputs; must be a multiple of `CHUNK`.
- `CHUNK`, 8: input slice width accepted per handshake.
- `DELAY_RISE`, 0: rise delay applied to `Y` only.
- `DELAY_FALL`, 0: fall delay applied to `Y` only.
- Derived: `NUM_CHUNKS` = `WIDTH_IN`/`CHUNK`.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Clear` input 1: reset, synchronous and active-high.
- `Start` input 1: begin an evaluation; sampled only when idle.
- `Mode` input 3: `[1:0]` op (00 AND, 01 OR, 10 XOR, 11 reserved, treated as AND); `[2]` invert result. 100 = NAND.
- `A` input `CHUNK`: current operand slice; slice 0 holds the LSBs.
- `A_Valid` input 1: `A` holds a valid slice.
- `A_Ready` output 1: block accepts a slice this cycle.
- `Y` output 1: registered gate result, held until the next result.
- `Y_Valid` output 1: one-cycle pulse when `Y` updates.
- `Busy` output 1: evaluation in progress.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `A_Ready`=0, `Busy`=0.
  - When `Start`=1: latch `Mode`, set the accumulator to the op identity (AND→1, OR→0, XOR→0), clear the chunk counter, go to ACCUM.
- ACCUM:
  - `A_Ready`=1, `Busy`=1.
  - On `A_Valid & A_Ready`: reduce `A` with the latched op, combine the result into the accumulator, increment the counter.
  - On acceptance of slice `NUM_CHUNKS-1`: go to DONE.
  - `A_Valid`=0 stalls indefinitely with no state change.
- DONE (one cycle):
  - `Y` ← accumulator XOR latched `Mode[2]`.
  - `Y_Valid`=1, `Busy`=1, `A_Ready`=0.
  - Go to IDLE.
- `Start` outside IDLE is ignored. `Mode` changes after latching are ignored.
- `Start` and `A_Valid` high in the same IDLE cycle: the slice is not consumed because `A_Ready`=0.
- `Clear` overrides everything. Next state is IDLE; accumulator and counter are zeroed; any partial evaluation is discarded with no `Y_Valid`.
- Reset values: `Y`=0, `Y_Valid`=0, `A_Ready`=0, `Busy`=0.
- `NUM_CHUNKS`=1 is legal: one slice in ACCUM, then DONE.
- Counter width is `$clog2(NUM_CHUNKS+1)`. The counter never wraps because DONE is entered at the terminal count.

## Timing
- `Start` sampled at edge 0. With `A_Valid` held high, slices are accepted at edges 1..`NUM_CHUNKS`. `Y`/`Y_Valid` update at edge `NUM_CHUNKS`+1.
- Minimum interval between `Start` acceptances is `NUM_CHUNKS`+2 cycles; a `Start` held high re-triggers in the IDLE cycle after DONE.
- `A_Ready` is a registered function of state only, with no combinational path from `A_Valid`.
- `Y` is driven through `assign #(DELAY_RISE, DELAY_FALL)`. `Y_Valid`, `A_Ready` and `Busy` carry no delay.

## Structure
- Shared package/include `ttl_gate_pkg`:
  - op encodings (`OP_AND`, `OP_OR`, `OP_XOR`) and the invert bit position;
  - state encodings;
  - identity-value function per op.
- Sub-module `ttl_reduce_chunk` (combinational, parameter `WIDTH`): reduces `CHUNK` bits under the op select. It is reusable by future wide-gate models.
- Top module holds the FSM, accumulator, counter and output register.

## Test plan
Configuration for all cases: `WIDTH_IN`=32, `CHUNK`=8.
- NAND all ones: `Mode`=100, slices FF,FF,FF,FF back-to-back → `Y`=0, `Y_Valid` pulse at edge 5, `Busy` high edges 1–5.
- NAND single zero: `Mode`=100, slices FF,FF,FE,FF → `Y`=1; repeat with `Mode`=000 → `Y`=0.
- Parity: `Mode`=010, slices 01,00,03,00 → `Y`=1; `Mode`=110 with the same slices → `Y`=0.
- Backpressure: `Mode`=001, slices 00,00,00,80 with `A_Valid` low 3 cycles between each → `Y`=1; `Y_Valid` exactly one cycle after the 4th acceptance; no extra acceptances.
- `Clear` mid-operation: after 2 of 4 slices → next cycle `Busy`=0, `A_Ready`=0, `Y`=0, no `Y_Valid`. A fresh `Start` with `Mode`=100 and four FF slices → `Y`=0.
- Ignored controls: `Start` pulsed and `Mode` changed to 001 during ACCUM → evaluation completes with the originally latched NAND result; exactly one `Y_Valid`.

Source files
------------

// File: rtl/ttl_gate_pkg.sv
// Shared definitions for the TTL gate models: op encodings, FSM states and
// per-op helper functions used by the wide reduction gates.
package ttl_gate_pkg;

    localparam int unsigned MODE_W       = 3;
    localparam int unsigned OP_W         = 2;
    localparam int unsigned MODE_INV_BIT = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Reserved encoding folds onto AND so downstream logic sees three ops only.
    function automatic op_e op_decode(input logic [OP_W-1:0] raw);
        case (raw)
            2'b01:   return OP_OR;
            2'b10:   return OP_XOR;
            default: return OP_AND;
        endcase
    endfunction

    function automatic logic op_identity(input op_e op);
        return (op == OP_AND || op == OP_RSVD);
    endfunction

    function automatic logic op_combine(input op_e op, input logic acc, input logic bit_in);
        case (op)
            OP_OR:   return acc | bit_in;
            OP_XOR:  return acc ^ bit_in;
            default: return acc & bit_in;
        endcase
    endfunction

endpackage

// File: rtl/ttl_reduce_chunk.sv
// Combinational reduction of one operand slice under an AND/OR/XOR select.
module ttl_reduce_chunk
    import ttl_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    output logic             y_c
);

    always_comb begin
        y_c = &a;
        case (op)
            OP_OR:   y_c = |a;
            OP_XOR:  y_c = ^a;
            default: y_c = &a;
        endcase
    end

endmodule

// File: rtl/ttl_reduce_gate_seq.sv
// Sequential wide gate: reduces a WIDTH_IN-bit operand delivered as CHUNK-bit
// slices over a valid/ready handshake, then pulses Y_Valid with the result.
module ttl_reduce_gate_seq
    import ttl_gate_pkg::*;
#(
    parameter int unsigned WIDTH_IN   = 32,
    parameter int unsigned CHUNK      = 8,
    parameter int unsigned DELAY_RISE = 0,
    parameter int unsigned DELAY_FALL = 0
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              Start,
    input  logic [MODE_W-1:0] Mode,
    input  logic [CHUNK-1:0]  A,
    input  logic              A_Valid,
    output logic              A_Ready,
    output logic              Y,
    output logic              Y_Valid,
    output logic              Busy
);

    localparam int unsigned NUM_CHUNKS = WIDTH_IN / CHUNK;
    localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    state_e           state;
    op_e              op_q;
    logic             inv_q;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic             y_q;
    logic             chunk_y_c;

    ttl_reduce_chunk #(.WIDTH(CHUNK)) u_chunk (
        .op  (op_q),
        .a   (A),
        .y_c (chunk_y_c)
    );

    // FSM, accumulator, counter and registered outputs in one process.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state   <= ST_IDLE;
            op_q    <= OP_AND;
            inv_q   <= 1'b0;
            acc     <= 1'b0;
            cnt     <= '0;
            y_q     <= 1'b0;
            Y_Valid <= 1'b0;
            A_Ready <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            Y_Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        op_q    <= op_decode(Mode[OP_W-1:0]);
                        inv_q   <= Mode[MODE_INV_BIT];
                        acc     <= op_identity(op_decode(Mode[OP_W-1:0]));
                        cnt     <= '0;
                        A_Ready <= 1'b1;
                        Busy    <= 1'b1;
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (A_Valid && A_Ready) begin
                        acc <= op_combine(op_q, acc, chunk_y_c);
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            A_Ready <= 1'b0;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    y_q     <= acc ^ inv_q;
                    Y_Valid <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    A_Ready <= 1'b0;
                    Busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Gate propagation delay only modelled when a non-zero delay is requested.
    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_y_nodly
        assign Y = y_q;
    end else begin : g_y_dly
        assign #(DELAY_RISE, DELAY_FALL) Y = y_q;
    end

endmodule

// File: tb/tb_ttl_reduce_gate_seq.sv
// Self-checking bench for ttl_reduce_gate_seq (WIDTH_IN=32, CHUNK=8).
module tb_ttl_reduce_gate_seq;

    localparam int unsigned WIDTH_IN   = 32;
    localparam int unsigned CHUNK      = 8;
    localparam int unsigned NUM_CHUNKS = WIDTH_IN / CHUNK;

    logic             Clk = 1'b0;
    logic             Clear;
    logic             Start;
    logic [2:0]       Mode;
    logic [CHUNK-1:0] A;
    logic             A_Valid;
    logic             A_Ready;
    logic             Y;
    logic             Y_Valid;
    logic             Busy;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int yv_cnt = 0;

    ttl_reduce_gate_seq #(
        .WIDTH_IN(WIDTH_IN), .CHUNK(CHUNK), .DELAY_RISE(0), .DELAY_FALL(0)
    ) dut (
        .Clk(Clk), .Clear(Clear), .Start(Start), .Mode(Mode), .A(A),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .Y(Y), .Y_Valid(Y_Valid), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Handshake and result-pulse monitors.
    always @(posedge Clk) begin
        if (A_Valid && A_Ready) acc_cnt++;
        if (Y_Valid) yv_cnt++;
    end

    // Reference: reduce the whole operand at once, then optionally invert.
    function automatic logic ref_gate(input logic [2:0] mode, input logic [WIDTH_IN-1:0] opnd);
        logic r;
        case (mode[1:0])
            2'b01:   r = |opnd;
            2'b10:   r = ^opnd;
            default: r = &opnd;
        endcase
        return r ^ mode[2];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Runs one evaluation; gap cycles of A_Valid=0 before slices 1..N-1
    // (or random 0..gap before every slice). lat = cycles from last accept to Y_Valid.
    task automatic run_op(input logic [2:0] mode, input logic [WIDTH_IN-1:0] opnd,
                          input int gap, input bit rand_gap, output bit tmo, output int lat);
        int n;
        tmo = 1'b0;
        Start = 1'b1; Mode = mode; A_Valid = 1'b0;
        step();
        Start = 1'b0;
        for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
            int st;
            st = rand_gap ? int'($urandom_range(gap, 0)) : ((i == 0) ? 0 : gap);
            repeat (st) step();
            A = opnd[i*CHUNK +: CHUNK];
            A_Valid = 1'b1;
            n = 0;
            while (!A_Ready && n < 20) begin step(); n++; end
            if (n >= 20) tmo = 1'b1;
            step();
            A_Valid = 1'b0;
        end
        n = 1;
        while (!Y_Valid && n < 10) begin step(); n++; end
        if (!Y_Valid) tmo = 1'b1;
        lat = n - 1;
    endtask

    task automatic test_reset();
        Clear = 1'b1; Start = 1'b1; Mode = 3'b100; A = 8'hFF; A_Valid = 1'b1;
        step(); step();
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL reset_y: got %b expected 0", Y); end
        checks++; if (Y_Valid !== 1'b0) begin errors++; $display("FAIL reset_yv: got %b expected 0", Y_Valid); end
        checks++; if (A_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", A_Ready); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        Clear = 1'b0; Start = 1'b0; A_Valid = 1'b0;
        step();
    endtask

    task automatic test_nand_all_ones();
        int a0, y0;
        a0 = acc_cnt; y0 = yv_cnt;
        Start = 1'b1; Mode = 3'b100;
        step();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1 || A_Ready !== 1'b1) begin errors++;
            $display("FAIL nand1_edge0: busy=%b ready=%b expected 1 1", Busy, A_Ready); end
        A = 8'hFF; A_Valid = 1'b1;
        for (int e = 1; e <= int'(NUM_CHUNKS); e++) begin
            step();
            checks++; if (Busy !== 1'b1 || Y_Valid !== 1'b0) begin errors++;
                $display("FAIL nand1_busy_e%0d: busy=%b yv=%b expected 1 0", e, Busy, Y_Valid); end
        end
        A_Valid = 1'b0;
        checks++; if (A_Ready !== 1'b0) begin errors++; $display("FAIL nand1_ready_done: got %b expected 0", A_Ready); end
        step();
        checks++; if (Y_Valid !== 1'b1 || Y !== ref_gate(3'b100, 32'hFFFFFFFF)) begin errors++;
            $display("FAIL nand1_result: yv=%b y=%b expected 1 %b", Y_Valid, Y, ref_gate(3'b100, 32'hFFFFFFFF)); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL nand1_busy_end: got %b expected 0", Busy); end
        step();
        checks++; if (Y_Valid !== 1'b0) begin errors++; $display("FAIL nand1_pulse_width: got %b expected 0", Y_Valid); end
        checks++; if (acc_cnt - a0 != 4 || yv_cnt - y0 != 1) begin errors++;
            $display("FAIL nand1_counts: accepts=%0d pulses=%0d expected 4 1", acc_cnt - a0, yv_cnt - y0); end
    endtask

    task automatic test_nand_single_zero();
        bit tmo; int lat;
        logic [2:0] modes [2] = '{3'b100, 3'b000};
        for (int k = 0; k < 2; k++) begin
            run_op(modes[k], 32'hFFFEFFFF, 0, 1'b0, tmo, lat);
            checks++; if (tmo || Y !== ref_gate(modes[k], 32'hFFFEFFFF)) begin errors++;
                $display("FAIL single_zero_m%b: y=%b tmo=%b expected %b", modes[k], Y, tmo, ref_gate(modes[k], 32'hFFFEFFFF)); end
            step();
        end
    endtask

    task automatic test_parity();
        bit tmo; int lat;
        logic [2:0] modes [2] = '{3'b010, 3'b110};
        for (int k = 0; k < 2; k++) begin
            run_op(modes[k], 32'h00030001, 0, 1'b0, tmo, lat);
            checks++; if (tmo || Y !== ref_gate(modes[k], 32'h00030001)) begin errors++;
                $display("FAIL parity_m%b: y=%b tmo=%b expected %b", modes[k], Y, tmo, ref_gate(modes[k], 32'h00030001)); end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit tmo; int lat, a0, y0;
        a0 = acc_cnt; y0 = yv_cnt;
        run_op(3'b001, 32'h80000000, 3, 1'b0, tmo, lat);
        checks++; if (tmo || Y !== ref_gate(3'b001, 32'h80000000)) begin errors++;
            $display("FAIL bp_result: y=%b tmo=%b expected %b", Y, tmo, ref_gate(3'b001, 32'h80000000)); end
        checks++; if (lat != 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", lat); end
        repeat (3) step();
        checks++; if (acc_cnt - a0 != 4 || yv_cnt - y0 != 1) begin errors++;
            $display("FAIL bp_counts: accepts=%0d pulses=%0d expected 4 1", acc_cnt - a0, yv_cnt - y0); end
    endtask

    task automatic test_clear_mid_op();
        bit tmo; int lat, y0;
        run_op(3'b001, 32'h01000000, 0, 1'b0, tmo, lat);
        checks++; if (tmo || Y !== 1'b1) begin errors++; $display("FAIL clear_setup: y=%b expected 1", Y); end
        step();
        y0 = yv_cnt;
        Start = 1'b1; Mode = 3'b010;
        step();
        Start = 1'b0; A = 8'h01; A_Valid = 1'b1;
        step(); step();
        A_Valid = 1'b0; Clear = 1'b1;
        step();
        Clear = 1'b0;
        checks++; if (Busy !== 1'b0 || A_Ready !== 1'b0 || Y !== 1'b0 || Y_Valid !== 1'b0) begin errors++;
            $display("FAIL clear_state: busy=%b ready=%b y=%b yv=%b expected 0 0 0 0", Busy, A_Ready, Y, Y_Valid); end
        A_Valid = 1'b1;
        repeat (6) step();
        A_Valid = 1'b0;
        checks++; if (yv_cnt != y0 || Busy !== 1'b0) begin errors++;
            $display("FAIL clear_no_result: pulses=%0d busy=%b expected 0 0", yv_cnt - y0, Busy); end
        run_op(3'b100, 32'hFFFFFFFF, 0, 1'b0, tmo, lat);
        checks++; if (tmo || Y !== ref_gate(3'b100, 32'hFFFFFFFF)) begin errors++;
            $display("FAIL clear_fresh: y=%b tmo=%b expected %b", Y, tmo, ref_gate(3'b100, 32'hFFFFFFFF)); end
        step();
    endtask

    task automatic test_ignored_controls();
        int a0, y0, n;
        a0 = acc_cnt; y0 = yv_cnt;
        Start = 1'b1; Mode = 3'b100;
        step();
        Start = 1'b0; A = 8'hFF; A_Valid = 1'b1;
        step();
        Start = 1'b1; Mode = 3'b001;
        step(); step();
        Start = 1'b0;
        step();
        A_Valid = 1'b0;
        n = 0;
        while (!Y_Valid && n < 10) begin step(); n++; end
        checks++; if (!Y_Valid || Y !== ref_gate(3'b100, 32'hFFFFFFFF)) begin errors++;
            $display("FAIL ignored_result: yv=%b y=%b expected 1 %b", Y_Valid, Y, ref_gate(3'b100, 32'hFFFFFFFF)); end
        Mode = 3'b000;
        repeat (4) step();
        checks++; if (acc_cnt - a0 != 4 || yv_cnt - y0 != 1 || Busy !== 1'b0) begin errors++;
            $display("FAIL ignored_counts: accepts=%0d pulses=%0d busy=%b expected 4 1 0", acc_cnt - a0, yv_cnt - y0, Busy); end
    endtask

    task automatic test_back_to_back();
        int t0, n;
        Start = 1'b1; Mode = 3'b010; A = 8'h07; A_Valid = 1'b1;
        n = 0;
        while (!Y_Valid && n < 20) begin step(); n++; end
        checks++; if (!Y_Valid || Y !== ref_gate(3'b010, 32'h07070707)) begin errors++;
            $display("FAIL b2b_first: yv=%b y=%b expected 1 %b", Y_Valid, Y, ref_gate(3'b010, 32'h07070707)); end
        step();
        t0 = 1; Mode = 3'b101; Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger: busy=%b expected 1", Busy); end
        while (!Y_Valid && t0 < 20) begin step(); t0++; end
        A_Valid = 1'b0;
        checks++; if (t0 != int'(NUM_CHUNKS) + 2 || Y !== ref_gate(3'b010, 32'h07070707)) begin errors++;
            $display("FAIL b2b_interval: got %0d y=%b expected %0d %b", t0, Y, NUM_CHUNKS + 2, ref_gate(3'b010, 32'h07070707)); end
        step();
    endtask

    task automatic test_random();
        bit tmo; int lat, a0, y0;
        logic [2:0] mode;
        logic [WIDTH_IN-1:0] opnd;
        for (int it = 0; it < 40; it++) begin
            mode = 3'($urandom);
            case ($urandom_range(2, 0))
                0:       opnd = $urandom;
                1:       opnd = '1;
                default: opnd = ~(32'h1 << $urandom_range(31, 0));
            endcase
            a0 = acc_cnt; y0 = yv_cnt;
            run_op(mode, opnd, 2, 1'b1, tmo, lat);
            checks++; if (tmo || Y !== ref_gate(mode, opnd) || lat != 1) begin errors++;
                $display("FAIL rand_%0d: mode=%b opnd=%h y=%b lat=%0d tmo=%b expected y=%b lat=1",
                         it, mode, opnd, Y, lat, tmo, ref_gate(mode, opnd)); end
            step();
            checks++; if (acc_cnt - a0 != 4 || yv_cnt - y0 != 1) begin errors++;
                $display("FAIL rand_counts_%0d: accepts=%0d pulses=%0d expected 4 1", it, acc_cnt - a0, yv_cnt - y0); end
        end
    endtask

    initial begin
        Clear = 1'b1; Start = 1'b0; Mode = '0; A = '0; A_Valid = 1'b0;
        test_reset();
        test_nand_all_ones();
        test_nand_single_zero();
        test_parity();
        test_backpressure();
        test_clear_mid_op();
        test_ignored_controls();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
